pc_gen: RTL and testbench

- Parametrised program-counter generator that replaces the bare PC register at the front of the fetch stage.
- Holds the current fetch PC and steps it by IALIGN-sized increments.
- Supports pipeline stall, branch/jump redirect, trap redirect, and a redirect captured while stalled (pending).
- Drives the next-PC address for synchronous-read instruction memory and a fetch-valid qualifier for IF.

---
 rtl/pc_gen_if.sv | 25 ++
 rtl/pc_gen.sv | 97 +++++++++
 tb/tb_pc_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-front control bundle: hazard/redirect/trap requests in, fetch PC and status out.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_next;
  logic            fetch_valid;
  logic            redirect_pending;
  logic            misaligned;

  modport master (
    output stall, redirect_valid, redirect_target, trap_valid, trap_target,
    input  pc_out, pc_next, fetch_valid, redirect_pending, misaligned
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap_valid, trap_target,
    output pc_out, pc_next, fetch_valid, redirect_pending, misaligned
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator with stall, redirect, trap and stall-deferred redirect.
//   state | meaning
//   BOOT  | first edge after reset; fetch the reset vector, ignore all requests
//   RUN   | normal sequencing with trap > pending > redirect > capture > stall > increment
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  ctrl_io
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] STEP     = XLEN'(IALIGN);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_mis_q, pend_mis_d;
  logic            mis_q, mis_d;

  logic [XLEN-1:0] redir_aligned;
  logic            redir_mis;
  logic [XLEN-1:0] trap_aligned;

  assign redir_aligned = ctrl_io.redirect_target & ~LOW_MASK;
  assign redir_mis     = |(ctrl_io.redirect_target & LOW_MASK);
  assign trap_aligned  = ctrl_io.trap_target & ~LOW_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      pend_mis_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      pend_mis_q <= pend_mis_d;
      mis_q      <= mis_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    pend_mis_d = pend_mis_q;
    mis_d      = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (ctrl_io.trap_valid) begin
          // A trap also flushes any deferred redirect, even under stall.
          pc_d   = trap_aligned;
          pend_d = 1'b0;
        end else if (pend_q && !ctrl_io.stall) begin
          pc_d   = pend_tgt_q;
          pend_d = 1'b0;
          mis_d  = pend_mis_q;
        end else if (ctrl_io.redirect_valid && !ctrl_io.stall) begin
          pc_d  = redir_aligned;
          mis_d = redir_mis;
        end else if (ctrl_io.redirect_valid && ctrl_io.stall && !pend_q) begin
          pend_d     = 1'b1;
          pend_tgt_d = redir_aligned;
          pend_mis_d = redir_mis;
        end else if (!ctrl_io.stall) begin
          pc_d = pc_q + STEP;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign ctrl_io.pc_out           = pc_q;
  assign ctrl_io.pc_next          = pc_d;
  assign ctrl_io.fetch_valid      = (state_q == RUN);
  assign ctrl_io.redirect_pending = pend_q;
  assign ctrl_io.misaligned       = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen: one IALIGN=4 instance and one IALIGN=2 instance.
module tb_pc_gen;

  logic clk;
  logic rst;

  pc_gen_if #(.XLEN(32)) if4 ();
  pc_gen_if #(.XLEN(32)) if2 ();

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h8000_0000), .IALIGN(4)) dut4 (
    .clk(clk), .rst(rst), .ctrl_io(if4)
  );
  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .IALIGN(2)) dut2 (
    .clk(clk), .rst(rst), .ctrl_io(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        pend;
    logic        mis;
    logic        fv;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests to the selected instance, check pc_next before the
  // edge, then pop the scoreboard entry and check registered outputs after it.
  task automatic step(input int sel, input string tag,
                      input logic st, input logic rv, input logic [31:0] rt,
                      input logic tv, input logic [31:0] tt,
                      input logic [31:0] e_pc, input logic e_pend, input logic e_mis);
    exp_t e;
    if (sel == 0) begin
      if4.stall = st; if4.redirect_valid = rv; if4.redirect_target = rt;
      if4.trap_valid = tv; if4.trap_target = tt;
    end else begin
      if2.stall = st; if2.redirect_valid = rv; if2.redirect_target = rt;
      if2.trap_valid = tv; if2.trap_target = tt;
    end
    e.tag = tag; e.pc = e_pc; e.pend = e_pend; e.mis = e_mis; e.fv = 1'b1;
    sb.push_back(e);
    #1;
    chk({tag, "/pc_next"}, (sel == 0) ? if4.pc_next : if2.pc_next, e_pc);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s/queue: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "/pc"},   (sel == 0) ? if4.pc_out           : if2.pc_out,           e.pc);
      chk({e.tag, "/pend"}, (sel == 0) ? if4.redirect_pending : if2.redirect_pending, 32'(e.pend));
      chk({e.tag, "/mis"},  (sel == 0) ? if4.misaligned       : if2.misaligned,       32'(e.mis));
      chk({e.tag, "/fv"},   (sel == 0) ? if4.fetch_valid      : if2.fetch_valid,      32'(e.fv));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    if4.stall = 0; if4.redirect_valid = 0; if4.redirect_target = '0;
    if4.trap_valid = 0; if4.trap_target = '0;
    if2.stall = 0; if2.redirect_valid = 0; if2.redirect_target = '0;
    if2.trap_valid = 0; if2.trap_target = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst/pc",      if4.pc_out,           32'h8000_0000);
    chk("rst/pc_next", if4.pc_next,          32'h8000_0000);
    chk("rst/fv",      32'(if4.fetch_valid),      32'd0);
    chk("rst/pend",    32'(if4.redirect_pending), 32'd0);
    chk("rst/mis",     32'(if4.misaligned),       32'd0);

    @(negedge clk);
    rst = 1'b0;
    step(0, "boot",  0, 0, 0, 0, 0, 32'h8000_0000, 0, 0);
    step(0, "seq1",  0, 0, 0, 0, 0, 32'h8000_0004, 0, 0);
    step(0, "seq2",  0, 0, 0, 0, 0, 32'h8000_0008, 0, 0);

    step(0, "to10",  0, 1, 32'h10, 0, 0, 32'h10, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, "stall", 1, 0, 0, 0, 0, 32'h10, 0, 0);
    step(0, "unst",  0, 0, 0, 0, 0, 32'h14, 0, 0);

    step(0, "to10b", 0, 1, 32'h10, 0, 0, 32'h10, 0, 0);
    step(0, "cap200", 1, 1, 32'h200, 0, 0, 32'h10, 1, 0);
    step(0, "ign300", 1, 1, 32'h300, 0, 0, 32'h10, 1, 0);
    step(0, "hold",   1, 0, 0, 0, 0, 32'h10, 1, 0);
    step(0, "apply",  0, 1, 32'h500, 0, 0, 32'h200, 0, 0);
    step(0, "after",  0, 0, 0, 0, 0, 32'h204, 0, 0);

    step(0, "cap600", 1, 1, 32'h600, 0, 0, 32'h204, 1, 0);
    step(0, "trap",   1, 1, 32'h400, 1, 32'h103, 32'h100, 0, 0);
    step(0, "ptrap",  0, 0, 0, 0, 0, 32'h104, 0, 0);

    step(0, "mis203", 0, 1, 32'h203, 0, 0, 32'h200, 0, 1);
    step(0, "mis_off", 0, 0, 0, 0, 0, 32'h204, 0, 0);
    step(0, "cap307", 1, 1, 32'h307, 0, 0, 32'h204, 1, 0);
    step(0, "app307", 0, 0, 0, 0, 0, 32'h304, 0, 1);
    step(0, "p307",   0, 0, 0, 0, 0, 32'h308, 0, 0);

    step(0, "toFFC",  0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 0);
    step(0, "wrap",   0, 0, 0, 0, 0, 32'h0, 0, 0);
    step(0, "wrap4",  0, 0, 0, 0, 0, 32'h4, 0, 0);
    step(0, "cap700", 1, 1, 32'h700, 0, 0, 32'h4, 1, 0);
    if4.redirect_valid = 0;

    step(1, "a2_203", 0, 1, 32'h203, 0, 0, 32'h202, 0, 1);
    step(1, "a2_seq", 0, 0, 0, 0, 0, 32'h204, 0, 0);
    step(1, "a2_trap", 0, 0, 0, 1, 32'h103, 32'h102, 0, 0);
    if2.trap_valid = 0;

    chk("pre_rst/pend", 32'(if4.redirect_pending), 32'd1);
    chk("pre_rst/pc",   if4.pc_out, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst/pc",    if4.pc_out, 32'h8000_0000);
    chk("arst/fv",    32'(if4.fetch_valid),      32'd0);
    chk("arst/pend",  32'(if4.redirect_pending), 32'd0);
    chk("arst/pc2",   if2.pc_out, 32'h0);
    chk("arst/fv2",   32'(if2.fetch_valid),      32'd0);

    @(negedge clk);
    rst = 1'b0;
    step(0, "reboot", 1, 1, 32'h900, 0, 0, 32'h8000_0000, 0, 0);
    step(0, "rseq",   0, 0, 0, 0, 0, 32'h8000_0004, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
